ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable-scanning) to the keyboard over the same open-drain `ps2_clock`/`ps2_data` lines the io block already receives on. It performs the inhibit/request-to-send sequence, shifts the byte LSB first with odd parity on device-generated clock edges, and checks the device acknowledge. It sits beside the PS/2 receiver inside io. While active, it asserts `rx_inhibit` so the receiver ignores line activity.

---
 rtl/ps2_transmitter_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_transmitter.sv | 154 +++++++++++++++
 tb/tb_ps2_transmitter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_transmitter_pkg.sv
// Shared PS/2 transmitter types: FSM encoding, frame geometry and default timing.
package ps2_transmitter_pkg;

    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_INHIBIT   = 3'd1,
        TX_RELEASE   = 3'd2,
        TX_SHIFT     = 3'd3,
        TX_ACK       = 3'd4,
        TX_WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    // Start + 8 data + parity + stop; the 11th device falling edge carries the ACK.
    localparam int PS2_FRAME_BITS             = 11;
    localparam int PS2_INHIBIT_CYCLES_DEFAULT = 2000;
    localparam int PS2_TIMEOUT_CYCLES_DEFAULT = 300000;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge detector for one open-drain PS/2 line.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: request-to-send, LSB-first shift
// with odd parity on device clock edges, and acknowledge check.
module ps2_transmitter
    import ps2_transmitter_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    tx_data,
    input  logic          tx_start,
    output logic          tx_ready,
    output logic          tx_done,
    output logic          tx_error,
    output logic          rx_inhibit,
    input  logic          ps2_clock,
    input  logic          ps2_data,
    output logic          ps2_clock_drive_low,
    output logic          ps2_data_drive_low,
    output ps2_tx_state_e tx_state
);

    // Handshake: a byte is taken on any rising clk edge where tx_start and
    // tx_ready are both 1; tx_ready stays 0 until the next byte can be taken,
    // including the cycle that carries the tx_done/tx_error pulse.

    localparam int MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] START_BIT_AT = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_EDGE    = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_e                   state;
    logic [PS2_FRAME_BITS-2:0]       frame;
    logic [3:0]                      edge_cnt;
    logic [CW-1:0]                   cycle_cnt;

    logic clock_level;
    logic clock_fall;
    logic data_level;
    logic data_fall_unused;

    ps2_line_sync u_clock_sync (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_clock),
        .level (clock_level),
        .fall  (clock_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_data),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    assign tx_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= TX_IDLE;
            frame               <= '0;
            edge_cnt            <= '0;
            cycle_cnt           <= '0;
            ps2_clock_drive_low <= 1'b0;
            ps2_data_drive_low  <= 1'b0;
            tx_ready            <= 1'b1;
            tx_done             <= 1'b0;
            tx_error            <= 1'b0;
            rx_inhibit          <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                TX_IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_start && tx_ready) begin
                        frame               <= {1'b1, odd_parity(tx_data), tx_data};
                        cycle_cnt           <= '0;
                        ps2_clock_drive_low <= 1'b1;
                        tx_ready            <= 1'b0;
                        rx_inhibit          <= 1'b1;
                        state               <= TX_INHIBIT;
                    end
                end

                // Clock held low for exactly INHIBIT_CYCLES; the start bit
                // goes down on the last of those cycles.
                TX_INHIBIT: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    if (cycle_cnt == START_BIT_AT) begin
                        ps2_data_drive_low <= 1'b1;
                    end
                    if (cycle_cnt == INHIBIT_LAST) begin
                        ps2_clock_drive_low <= 1'b0;
                        cycle_cnt           <= '0;
                        edge_cnt            <= '0;
                        state               <= TX_RELEASE;
                    end
                end

                TX_RELEASE: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    state     <= TX_SHIFT;
                end

                TX_SHIFT, TX_ACK, TX_WAIT_IDLE: begin
                    cycle_cnt <= cycle_cnt + CW'(1);
                    if (cycle_cnt == TIMEOUT_LAST) begin
                        ps2_clock_drive_low <= 1'b0;
                        ps2_data_drive_low  <= 1'b0;
                        tx_error            <= 1'b1;
                        rx_inhibit          <= 1'b0;
                        state               <= TX_IDLE;
                    end else if (state == TX_SHIFT) begin
                        if (clock_fall) begin
                            edge_cnt <= edge_cnt + 4'd1;
                            if (edge_cnt == LAST_EDGE) begin
                                state <= TX_ACK;
                            end else begin
                                ps2_data_drive_low <= ~frame[edge_cnt];
                            end
                        end
                    end else if (state == TX_ACK) begin
                        if (!data_level) begin
                            state <= TX_WAIT_IDLE;
                        end else begin
                            tx_error   <= 1'b1;
                            rx_inhibit <= 1'b0;
                            state      <= TX_IDLE;
                        end
                    end else if (clock_level && data_level) begin
                        tx_done    <= 1'b1;
                        rx_inhibit <= 1'b0;
                        state      <= TX_IDLE;
                    end
                end

                default: begin
                    ps2_clock_drive_low <= 1'b0;
                    ps2_data_drive_low  <= 1'b0;
                    rx_inhibit          <= 1'b0;
                    state               <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain device model, frame scoreboard and timing monitors.
module tb_ps2_transmitter;
    import ps2_transmitter_pkg::*;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 1500;
    localparam int W       = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_start = 1'b0;
    logic          tx_ready;
    logic          tx_done;
    logic          tx_error;
    logic          rx_inhibit;
    logic          clk_drv;
    logic          data_drv;
    ps2_tx_state_e tx_state;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_line;
    logic data_line;

    assign clk_line  = ~(clk_drv | dev_clk_low);
    assign data_line = ~(data_drv | dev_data_low);

    ps2_transmitter #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .tx_data             (tx_data),
        .tx_start            (tx_start),
        .tx_ready            (tx_ready),
        .tx_done             (tx_done),
        .tx_error            (tx_error),
        .rx_inhibit          (rx_inhibit),
        .ps2_clock           (clk_line),
        .ps2_data            (data_line),
        .ps2_clock_drive_low (clk_drv),
        .ps2_data_drive_low  (data_drv),
        .tx_state            (tx_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int tests_run = 0;
    int fail_cnt  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: data LSB first, then a parity bit that makes the
    // number of ones odd, then the released (1) stop bit.
    function automatic logic [W-1:0] ref_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    // monitors
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   inhibit_viol = 0;
    int   clk_low_run = 0;
    int   overlap_run = 0;
    int   last_clk_low = 0;
    int   last_overlap = 0;
    int   release_cyc = 0;
    int   err_cyc = 0;
    logic [1:0] drives_at_err = 2'b00;
    logic prev_clk_drv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
            drives_at_err = {clk_drv, data_drv};
        end
        if (tx_done && tx_error) both_cnt++;
        if ((clk_drv || data_drv || tx_state != TX_IDLE) && !rx_inhibit) inhibit_viol++;
        if (clk_drv) clk_low_run++;
        if (clk_drv && data_drv) overlap_run++;
        if (prev_clk_drv && !clk_drv) begin
            release_cyc  = cyc;
            last_clk_low = clk_low_run;
            last_overlap = overlap_run;
            clk_low_run  = 0;
            overlap_run  = 0;
        end
        prev_clk_drv = clk_drv;
    end

    // driver tasks
    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        if (tx_ready) exp_q.push_back(ref_frame(d));
        @(negedge clk);
        tx_start = 1'b0;
        check("accept", {29'd0, tx_ready, rx_inhibit, clk_drv}, 32'b011);
    endtask

    // Device side: wait for request-to-send, clock 11 edges, read bits on
    // rising edges, optionally drive ACK for edge 11, optionally reset mid-frame.
    task automatic device_rx(input bit give_ack, input int abort_edge,
                             output logic [W-1:0] bits, output bit rts_seen);
        int guard;
        int half;
        bits = '0;
        rts_seen = 1'b0;
        guard = 0;
        while (!(data_line === 1'b0 && clk_line === 1'b1) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) return;
        rts_seen = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            half = $urandom_range(6, 12);
            dev_clk_low = 1'b1;
            if (abort_edge == i + 1) begin
                repeat (5) @(negedge clk);
                reset = 1'b0;
                #1;
                check("reset_drives", {30'd0, clk_drv, data_drv}, 32'b00);
                check("reset_pulses", {30'd0, tx_done, tx_error}, 32'b00);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                return;
            end
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = data_line;
            if (i == 9 && give_ack) dev_data_low = 1'b1;
            repeat (half) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic finish_transfer(input bit give_ack, input bit poke_done,
                                   input int d0, input int e0);
        int guard;
        guard = 0;
        while (!tx_done && !tx_error && guard < 2 * TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        if (poke_done && tx_done) begin
            tx_data  = 8'hAA;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
        end else begin
            @(negedge clk);
        end
        check("done_count", done_cnt - d0, give_ack ? 1 : 0);
        check("error_count", err_cnt - e0, give_ack ? 0 : 1);
        repeat (3) @(negedge clk);
        check("idle_after", {28'd0, tx_ready, rx_inhibit, clk_drv, data_drv}, 32'b1000);
    endtask

    task automatic check_frame(input logic [W-1:0] bits, input bit rts);
        check("rts_seen", rts, 1);
        check("exp_q_size", exp_q.size(), 1);
        if (exp_q.size() > 0) check("frame_bits", bits, exp_q.pop_front());
        check("inhibit_len", last_clk_low, INHIBIT);
        check("start_lead", last_overlap, 1);
    endtask

    task automatic run_transfer(input logic [7:0] d, input bit give_ack, input bit poke_done);
        logic [W-1:0] bits;
        bit rts;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        device_rx(give_ack, 0, bits, rts);
        check_frame(bits, rts);
        finish_transfer(give_ack, poke_done, d0, e0);
    endtask

    task automatic busy_transfer(input logic [7:0] d);
        logic [W-1:0] bits;
        bit rts;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        fork
            device_rx(1'b1, 0, bits, rts);
            begin
                repeat (40) @(negedge clk);
                check("busy_ready", tx_ready, 0);
                tx_data  = 8'hAA;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        check_frame(bits, rts);
        finish_transfer(1'b1, 1'b0, d0, e0);
    endtask

    task automatic timeout_transfer(input logic [7:0] d);
        int d0, guard;
        d0 = done_cnt;
        send(d);
        guard = 0;
        while (!tx_error && guard < TIMEOUT + INHIBIT + 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("timeout_seen", tx_error === 1'b1 || guard < TIMEOUT + INHIBIT + 200, 1);
        check("timeout_delay", err_cyc - release_cyc, TIMEOUT);
        check("timeout_drives", drives_at_err, 2'b00);
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_q", exp_q.size(), 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("timeout_idle", {29'd0, tx_ready, clk_drv, data_drv}, 32'b100);
    endtask

    task automatic reset_mid_transfer(input logic [7:0] d);
        logic [W-1:0] bits;
        bit rts;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        device_rx(1'b1, 5, bits, rts);
        check("abort_rts", rts, 1);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_error", err_cnt - e0, 0);
        check("abort_idle", {30'd0, tx_ready, rx_inhibit}, 32'b10);
        exp_q.delete();
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // main sequence
    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_pulses", {30'd0, tx_done, tx_error}, 32'b00);
        check("rst_drives", {29'd0, rx_inhibit, clk_drv, data_drv}, 32'b000);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_ready", tx_ready, 1);

        run_transfer(8'hED, 1'b1, 1'b1);
        run_transfer(8'hF4, 1'b1, 1'b0);
        timeout_transfer(8'h3C);
        run_transfer(8'h5B, 1'b0, 1'b0);
        reset_mid_transfer(8'h86);
        run_transfer(8'h00, 1'b1, 1'b0);
        busy_transfer(8'h5A);

        for (int n = 0; n < 6; n++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            run_transfer(d, $urandom_range(0, 3) != 0, n[0]);
        end

        check("never_both_pulses", both_cnt, 0);
        check("rx_inhibit_held", inhibit_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
